// File: rtl/huffman_stream_feeder.sv
// Bit-stream sequencer ahead of the Huffman decoder: packs upstream words
// into a left-aligned buffer and retires decoder-reported code lengths.
module huffman_stream_feeder #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  sym_count,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [9:0]        window,
  output logic              window_valid,
  input  logic              dec_done,
  input  logic [3:0]        dec_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  sym_idx
);

  localparam int BUF_W  = 2 * WORD_W;
  localparam int FILL_W = $clog2(BUF_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;

  logic               len_ok;
  logic               consume;
  logic               accept;
  logic [BUF_W-1:0]   buf_base;
  logic [FILL_W-1:0]  fill_base;
  logic [BUF_W-1:0]   word_ext;
  logic [CNT_W-1:0]   idx_inc;

  assign in_ready     = (state_q == S_RUN) &&
                        (fill_q <= FILL_W'(BUF_W - WORD_W));
  assign window_valid = (state_q == S_RUN) && (fill_q >= FILL_W'(10));
  assign window       = buf_q[BUF_W-1 -: 10];
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign sym_idx      = idx_q;

  assign len_ok   = (dec_len != 4'd0) && (dec_len <= 4'd10);
  assign consume  = dec_done && window_valid && len_ok;
  assign accept   = in_valid && in_ready;
  assign word_ext = {in_data, {WORD_W{1'b0}}};
  assign idx_inc  = idx_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    fill_d    = fill_q;
    idx_d     = idx_q;
    tgt_d     = tgt_q;
    buf_base  = buf_q;
    fill_base = fill_q;
    if (start && (state_q != S_RUN)) begin
      buf_d   = '0;
      fill_d  = '0;
      idx_d   = '0;
      tgt_d   = sym_count;
      // An empty frame finishes at once so no word is ever taken.
      state_d = (sym_count == '0) ? S_DONE : S_RUN;
    end else if (state_q == S_RUN) begin
      if (dec_done && !consume) begin
        state_d = S_ERR;
      end else begin
        if (consume) begin
          buf_base  = buf_q << dec_len;
          fill_base = fill_q - FILL_W'(dec_len);
          idx_d     = idx_inc;
          if (idx_inc == tgt_q) state_d = S_DONE;
        end
        buf_d  = buf_base;
        fill_d = fill_base;
        // Append below whatever survived this cycle's shift.
        if (accept) begin
          buf_d  = buf_base | (word_ext >> fill_base);
          fill_d = fill_base + FILL_W'(WORD_W);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_huffman_stream_feeder.sv
// Randomized bench for huffman_stream_feeder against a bit-queue
// reference model of the stream.
module tb_huffman_stream_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] sym_count;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  window;
  logic        window_valid;
  logic        dec_done;
  logic [3:0]  dec_len;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] sym_idx;

  huffman_stream_feeder #(.WORD_W(16), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sym_count    (sym_count),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .window       (window),
    .window_valid (window_valid),
    .dec_done     (dec_done),
    .dec_len      (dec_len),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .sym_idx      (sym_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 0 idle, 1 run, 2 done, 3 err
  int m_state = 0;
  int m_idx   = 0;
  int m_tgt   = 0;
  bit mq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit         run;
    logic [9:0] w;
    run = (m_state == 1);
    chk("busy", busy, run);
    chk("done", done, m_state == 2);
    chk("err", err, m_state == 3);
    chk("in_ready", in_ready, run && mq.size() <= 16);
    chk("window_valid", window_valid, run && mq.size() >= 10);
    chk("sym_idx", sym_idx, m_idx);
    if (run && mq.size() >= 10) begin
      for (int i = 0; i < 10; i++) w[9-i] = mq[i];
      chk("window", window, w);
    end
  endtask

  task automatic model_step(input bit st, input int sc, input bit iv,
                            input logic [15:0] d, input bit dd,
                            input int dl);
    bit wv;
    bit rdy;
    if (st && m_state != 1) begin
      mq.delete();
      m_idx   = 0;
      m_tgt   = sc;
      m_state = (sc == 0) ? 2 : 1;
    end else if (m_state == 1) begin
      wv  = mq.size() >= 10;
      rdy = mq.size() <= 16;
      if (dd && (!wv || dl == 0 || dl > 10)) begin
        m_state = 3;
      end else begin
        if (dd) begin
          repeat (dl) void'(mq.pop_front());
          m_idx++;
          if (m_idx == m_tgt) m_state = 2;
        end
        if (iv && rdy)
          for (int i = 15; i >= 0; i--) mq.push_back(d[i]);
      end
    end
  endtask

  task automatic cycle(input bit st, input int sc, input bit iv,
                       input logic [15:0] d, input bit dd, input int dl);
    check_outputs();
    start     = st;
    sym_count = 16'(sc);
    in_valid  = iv;
    in_data   = d;
    dec_done  = dd;
    dec_len   = 4'(dl);
    model_step(st, sc, iv, d, dd, dl);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic rand_cycle(input bit err_en);
    bit          iv;
    bit          dd;
    int          dl;
    logic [15:0] d;
    iv = 1'($urandom_range(0, 1));
    d  = 16'($urandom);
    dd = (mq.size() >= 10) && ($urandom_range(0, 2) != 0);
    dl = $urandom_range(1, 10);
    if (err_en && $urandom_range(0, 99) < 2) begin
      dd = 1;
      dl = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(11, 15);
    end
    cycle(0, 0, iv, d, dd, dl);
  endtask

  task automatic run_to_end(input bit err_en, input int budget);
    int n;
    n = 0;
    while (m_state == 1 && n < budget) begin
      rand_cycle(err_en);
      n++;
    end
    chk("frame_ended", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 0; sym_count = 0; in_data = 0; in_valid = 0;
    dec_done = 0; dec_len = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_window", window, 10'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    idle_cycle();

    // empty frame
    cycle(1, 0, 0, 16'h0, 0, 0);
    chk("empty_done", done, 1'b1);
    cycle(0, 0, 1, 16'hFFFF, 0, 0);
    chk("empty_no_accept", in_ready, 1'b0);
    idle_cycle();

    // single word, lengths 1,4,5
    cycle(1, 3, 0, 16'h0, 0, 0);
    cycle(0, 0, 1, 16'hB6C0, 0, 0);
    chk("w0", window, 10'b1011011011);
    cycle(0, 0, 0, 16'h0, 1, 1);
    chk("w1", window, 10'b0110110110);
    cycle(0, 0, 0, 16'h0, 1, 4);
    chk("w2", window, 10'b1101100000);
    cycle(0, 0, 0, 16'h0, 1, 5);
    chk("single_idx", sym_idx, 16'd3);
    chk("single_done", done, 1'b1);
    idle_cycle();

    // simultaneous accept and consume at fill 12
    cycle(1, 10, 0, 16'h0, 0, 0);
    cycle(0, 0, 1, 16'hF00F, 0, 0);
    cycle(0, 0, 0, 16'h0, 1, 4);
    cycle(0, 0, 1, 16'h5A3C, 1, 6);
    chk("simul_window", window, 10'b0011110101);
    run_to_end(0, 600);
    idle_cycle();

    // error: consume without a valid window
    cycle(1, 5, 0, 16'h0, 0, 0);
    cycle(0, 0, 0, 16'h0, 1, 3);
    chk("err_nowin", err, 1'b1);
    chk("err_nowin_idx", sym_idx, 16'd0);
    idle_cycle();
    // error: zero length
    cycle(1, 2, 0, 16'h0, 0, 0);
    chk("recover_err", err, 1'b0);
    cycle(0, 0, 1, 16'h1234, 0, 0);
    cycle(0, 0, 0, 16'h0, 1, 3);
    cycle(0, 0, 0, 16'h0, 1, 0);
    chk("err_len0", err, 1'b1);
    chk("err_len0_idx", sym_idx, 16'd1);
    cycle(1, 1, 0, 16'h0, 0, 0);
    chk("recover_busy", busy, 1'b1);
    run_to_end(0, 600);

    // mid-frame asynchronous reset
    cycle(1, 50, 0, 16'h0, 0, 0);
    for (int n = 0; n < 300 && m_idx < 5 && m_state == 1; n++)
      rand_cycle(0);
    chk("pre_rst_idx", sym_idx, 16'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_idx", sym_idx, 16'd0);
    chk("arst_wvalid", window_valid, 1'b0);
    chk("arst_window", window, 10'h0);
    chk("arst_ready", in_ready, 1'b0);
    m_state = 0; m_idx = 0; m_tgt = 0; mq.delete();
    start = 0; in_valid = 0; dec_done = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 2, 0, 16'h0, 0, 0);
    cycle(0, 0, 1, 16'hC3A5, 0, 0);
    chk("fresh_window", window, 10'b1100001110);
    run_to_end(0, 600);

    // random frames
    for (int f = 0; f < 12; f++) begin
      cycle(1, $urandom_range(1, 25), 0, 16'h0, 0, 0);
      run_to_end(1, 800);
      idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
